// File: rtl/module_b_arbiter_pkg.sv
// Shared types and constants for the moduleB round-robin arbiter.
// This package holds the payload widths, the parameter defaults and the FSM state encoding.
package module_b_arbiter_pkg;

   localparam int DATA_TO_B_BITWIDTH   = 8;
   localparam int B_EXTRA_IN_BITWIDTH  = 2;
   localparam int DATA_FROM_B_BITWIDTH = 8;
   localparam int B_EXTRA_OUT_BITWIDTH = 2;

   localparam int NUM_REQ_DEF   = 4;
   localparam int B_LATENCY_DEF = 2;
   localparam int LAT_W         = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_e;

endpackage

// File: rtl/module_b_arbiter_if.sv
// Requester-side request/response bundle shared by all NUM_REQ requesters.
// Requester i's payload occupies slice i of req_data and req_extra.
interface module_b_arbiter_if
   import module_b_arbiter_pkg::*;
#(
   parameter int NUM_REQ = NUM_REQ_DEF
);

   logic [NUM_REQ-1:0]                      req_valid;
   logic [NUM_REQ-1:0]                      req_ready;
   logic [NUM_REQ*DATA_TO_B_BITWIDTH-1:0]   req_data;
   logic [NUM_REQ*B_EXTRA_IN_BITWIDTH-1:0]  req_extra;
   logic [NUM_REQ-1:0]                      rsp_valid;
   logic [NUM_REQ-1:0]                      rsp_ready;
   logic [DATA_FROM_B_BITWIDTH-1:0]         rsp_data;
   logic [B_EXTRA_OUT_BITWIDTH-1:0]         rsp_extra;

   modport master (
      output req_valid, req_data, req_extra, rsp_ready,
      input  req_ready, rsp_valid, rsp_data, rsp_extra
   );

   modport slave (
      input  req_valid, req_data, req_extra, rsp_ready,
      output req_ready, rsp_valid, rsp_data, rsp_extra
   );

endinterface

// File: rtl/module_b_arbiter_rr_pick.sv
// Combinational rotate-priority encoder.
// It picks the first set req bit at or after ptr and wraps modulo N.
module rr_pick #(
   parameter int N    = 4,
   parameter int ID_W = $clog2(N)
) (
   input  logic [N-1:0]    req,
   input  logic [ID_W-1:0] ptr,
   output logic [N-1:0]    gnt,
   output logic [ID_W-1:0] gnt_id
);

   logic found;
   int   idx;

   always_comb begin
      gnt    = '0;
      gnt_id = '0;
      found  = 1'b0;
      idx    = 0;
      for (int k = 0; k < N; k++) begin
         idx = (int'(ptr) + k) % N;
         if (!found && req[idx]) begin
            found    = 1'b1;
            gnt[idx] = 1'b1;
            gnt_id   = ID_W'(idx);
         end
      end
   end

endmodule

// File: rtl/module_b_arbiter.sv
// Round-robin arbiter that shares one moduleB among NUM_REQ requesters.
// One transaction is outstanding at a time.
module module_b_arbiter
   import module_b_arbiter_pkg::*;
#(
   parameter int NUM_REQ   = NUM_REQ_DEF,
   parameter int B_LATENCY = B_LATENCY_DEF,
   localparam int ID_W     = $clog2(NUM_REQ)
) (
   input  logic                            clk,
   input  logic                            rst_n,
   module_b_arbiter_if.slave               req_if,
   output logic [DATA_TO_B_BITWIDTH-1:0]   data_to_B,
   output logic [B_EXTRA_IN_BITWIDTH-1:0]  b_extra_in,
   input  logic [DATA_FROM_B_BITWIDTH-1:0] data_from_B,
   input  logic [B_EXTRA_OUT_BITWIDTH-1:0] b_extra_out,
   output logic                            busy,
   output logic [ID_W-1:0]                 grant_id
);

   localparam int DW = DATA_TO_B_BITWIDTH;
   localparam int XW = B_EXTRA_IN_BITWIDTH;

   state_e                          state_q, state_d;
   logic [ID_W-1:0]                 rr_ptr_q, rr_ptr_d;
   logic [ID_W-1:0]                 grant_id_q, grant_id_d;
   logic [LAT_W-1:0]                lat_cnt_q, lat_cnt_d;
   logic [DW-1:0]                   data_to_b_q, data_to_b_d;
   logic [XW-1:0]                   b_extra_in_q, b_extra_in_d;
   logic [NUM_REQ-1:0]              rsp_valid_q, rsp_valid_d;
   logic [DATA_FROM_B_BITWIDTH-1:0] rsp_data_q, rsp_data_d;
   logic [B_EXTRA_OUT_BITWIDTH-1:0] rsp_extra_q, rsp_extra_d;
   logic [NUM_REQ-1:0]              pick_gnt;
   logic [ID_W-1:0]                 pick_id;
   logic [NUM_REQ-1:0]              req_ready_c;

   rr_pick #(.N(NUM_REQ), .ID_W(ID_W)) u_rr_pick (
      .req    (req_if.req_valid),
      .ptr    (rr_ptr_q),
      .gnt    (pick_gnt),
      .gnt_id (pick_id)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         rr_ptr_q     <= '0;
         grant_id_q   <= '0;
         lat_cnt_q    <= '0;
         data_to_b_q  <= '0;
         b_extra_in_q <= '0;
         rsp_valid_q  <= '0;
         rsp_data_q   <= '0;
         rsp_extra_q  <= '0;
      end else begin
         state_q      <= state_d;
         rr_ptr_q     <= rr_ptr_d;
         grant_id_q   <= grant_id_d;
         lat_cnt_q    <= lat_cnt_d;
         data_to_b_q  <= data_to_b_d;
         b_extra_in_q <= b_extra_in_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_data_q   <= rsp_data_d;
         rsp_extra_q  <= rsp_extra_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      rr_ptr_d     = rr_ptr_q;
      grant_id_d   = grant_id_q;
      lat_cnt_d    = lat_cnt_q;
      data_to_b_d  = data_to_b_q;
      b_extra_in_d = b_extra_in_q;
      rsp_valid_d  = rsp_valid_q;
      rsp_data_d   = rsp_data_q;
      rsp_extra_d  = rsp_extra_q;
      req_ready_c  = '0;
      unique case (state_q)
         ST_IDLE: begin
            req_ready_c = pick_gnt;
            if (|req_if.req_valid) begin
               data_to_b_d  = req_if.req_data[int'(pick_id)*DW +: DW];
               b_extra_in_d = req_if.req_extra[int'(pick_id)*XW +: XW];
               grant_id_d   = pick_id;
               lat_cnt_d    = LAT_W'(B_LATENCY - 1);
               state_d      = ST_WAIT;
            end
         end
         ST_WAIT: begin
            // moduleB output is only trusted once the full latency has elapsed
            if (lat_cnt_q == '0) begin
               rsp_data_d              = data_from_B;
               rsp_extra_d             = b_extra_out;
               rsp_valid_d             = '0;
               rsp_valid_d[grant_id_q] = 1'b1;
               state_d                 = ST_RESP;
            end else begin
               lat_cnt_d = lat_cnt_q - LAT_W'(1);
            end
         end
         ST_RESP: begin
            if (req_if.rsp_ready[grant_id_q]) begin
               rsp_valid_d = '0;
               rr_ptr_d    = (grant_id_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_id_q + ID_W'(1);
               state_d     = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign req_if.req_ready = req_ready_c;
   assign req_if.rsp_valid = rsp_valid_q;
   assign req_if.rsp_data  = rsp_data_q;
   assign req_if.rsp_extra = rsp_extra_q;
   assign data_to_B        = data_to_b_q;
   assign b_extra_in       = b_extra_in_q;
   assign grant_id         = grant_id_q;
   assign busy             = (state_q != ST_IDLE);

endmodule
